serial_adder_ctrl: RTL and testbench

Bit-serial adder controller that time-shares a single `full_adder` instance to add two `WIDTH`-bit operands, LSB first, one bit per clock. It captures operands on a start handshake and steps a counter-driven state machine over `WIDTH` cycles. While it steps, it shifts operand bits into the adder and feeds the registered carry back into `cin`. It sits wherever area matters more than latency, and is the sequencer for the existing one-bit adder datapath.

---
 rtl/serial_adder_ctrl.sv | 106 ++++++++++
 tb/tb_serial_adder_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one full_adder is reused for WIDTH cycles,
// LSB first, with the carry registered between bits.

module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic c
);
   assign s = a ^ b ^ cin;
   assign c = (a & b) | (a & cin) | (b & cin);
endmodule

module serial_adder_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic [1:0]       state_dbg
);
   // Handshake: an addition is accepted on a rising edge where start=1 and
   // ready=1; start in any other cycle is dropped, never queued.

   localparam int CW = (WIDTH < 2) ? 1 : $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] s_sh;
   logic             carry_q;
   logic [CW-1:0]    cnt;
   logic             fa_s;
   logic             fa_c;
   logic [WIDTH-1:0] s_next;

   full_adder u_fa (
      .a   (a_sh[0]),
      .b   (b_sh[0]),
      .cin (carry_q),
      .s   (fa_s),
      .c   (fa_c)
   );

   // New sum bit enters at the MSB; written as a shift/or so WIDTH=1 needs no special case.
   assign s_next = (s_sh >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         a_sh    <= '0;
         b_sh    <= '0;
         s_sh    <= '0;
         carry_q <= 1'b0;
         cnt     <= '0;
         sum     <= '0;
         cout    <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  a_sh    <= a;
                  b_sh    <= b;
                  carry_q <= cin;
                  cnt     <= '0;
                  state   <= S_RUN;
               end
            end
            S_RUN: begin
               a_sh    <= a_sh >> 1;
               b_sh    <= b_sh >> 1;
               s_sh    <= s_next;
               carry_q <= fa_c;
               cnt     <= cnt + CW'(1);
               if (cnt == LAST) begin
                  sum   <= s_next;
                  cout  <= fa_c;
                  state <= S_DONE;
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   assign ready     = (state == S_IDLE);
   assign busy      = (state == S_RUN);
   assign done      = (state == S_DONE);
   assign state_dbg = state;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl: WIDTH=8 protocol/timing cases plus
// WIDTH=1/5/16 instances driven in parallel against an arithmetic model.

module tb_serial_adder_ctrl;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // ---------------- WIDTH=8 instance ----------------
   logic       start8 = 1'b0;
   logic [7:0] a8 = '0, b8 = '0;
   logic       cin8 = 1'b0;
   logic       ready8, busy8, done8, cout8;
   logic [7:0] sum8;
   logic [1:0] st8;

   serial_adder_ctrl #(.WIDTH(8)) u_w8 (
      .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
      .ready(ready8), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8),
      .state_dbg(st8)
   );

   // ---------------- WIDTH=1/5/16 instances, shared stimulus ----------------
   logic        start_s = 1'b0;
   logic [15:0] as = '0, bs = '0;
   logic        cs = 1'b0;
   logic        rdy1, bsy1, dn1, co1;
   logic [0:0]  sm1;
   logic [1:0]  st1;
   logic        rdy5, bsy5, dn5, co5;
   logic [4:0]  sm5;
   logic [1:0]  st5;
   logic        rdy16, bsy16, dn16, co16;
   logic [15:0] sm16;
   logic [1:0]  st16;

   serial_adder_ctrl #(.WIDTH(1)) u_w1 (
      .clk(clk), .rst(rst), .start(start_s), .a(as[0:0]), .b(bs[0:0]), .cin(cs),
      .ready(rdy1), .busy(bsy1), .done(dn1), .sum(sm1), .cout(co1), .state_dbg(st1)
   );
   serial_adder_ctrl #(.WIDTH(5)) u_w5 (
      .clk(clk), .rst(rst), .start(start_s), .a(as[4:0]), .b(bs[4:0]), .cin(cs),
      .ready(rdy5), .busy(bsy5), .done(dn5), .sum(sm5), .cout(co5), .state_dbg(st5)
   );
   serial_adder_ctrl #(.WIDTH(16)) u_w16 (
      .clk(clk), .rst(rst), .start(start_s), .a(as), .b(bs), .cin(cs),
      .ready(rdy16), .busy(bsy16), .done(dn16), .sum(sm16), .cout(co16), .state_dbg(st16)
   );

   // ---------------- checker ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One WIDTH=8 addition; called in the cycle that becomes cycle 0.
   // disturb: scramble operands every RUN cycle and pulse start in cycles 4 and 9.
   task automatic op8(input string tag, input logic [7:0] av, input logic [7:0] bv,
                      input logic cv, input logic [7:0] es, input logic ec, input bit disturb);
      int busy_n, done_n, done_at, hot_err;
      logic [7:0] s_at_done;
      logic       c_at_done;
      logic       rdy10;
      busy_n = 0; done_n = 0; done_at = 0; hot_err = 0;
      s_at_done = 'x; c_at_done = 1'bx; rdy10 = 1'b0;
      check({tag, ".ready0"}, 32'(ready8), 32'd1);
      a8 = av; b8 = bv; cin8 = cv; start8 = 1'b1;
      for (int c = 1; c <= 10; c++) begin
         step();
         start8 = 1'b0;
         if ((32'(ready8) + 32'(busy8) + 32'(done8)) != 1) hot_err++;
         if (busy8 && (c < 1 || c > 8)) hot_err++;
         if (busy8) busy_n++;
         if (done8) begin
            done_n++;
            done_at = c;
            s_at_done = sum8;
            c_at_done = cout8;
         end
         if (c == 10) rdy10 = ready8;
         if (disturb) begin
            a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b1;
            if (c == 4 || c == 9) start8 = 1'b1;
         end
      end
      start8 = 1'b0;
      check({tag, ".busy_cycles"}, busy_n, 8);
      check({tag, ".done_count"}, done_n, 1);
      check({tag, ".done_cycle"}, done_at, 9);
      check({tag, ".onehot"}, hot_err, 0);
      check({tag, ".sum"}, 32'(s_at_done), 32'(es));
      check({tag, ".cout"}, 32'(c_at_done), 32'(ec));
      check({tag, ".ready10"}, 32'(rdy10), 32'd1);
      check({tag, ".sum_hold"}, {23'd0, cout8, sum8}, {23'd0, ec, es});
   endtask

   // Parallel addition on the WIDTH=1/5/16 instances, checked against the model.
   task automatic op_small(input string tag, input logic [15:0] av, input logic [15:0] bv,
                           input logic cv);
      int d1, d5, d16, b1n;
      logic [1:0]  r1, e1;
      logic [5:0]  r5, e5;
      logic [16:0] r16, e16;
      d1 = 0; d5 = 0; d16 = 0; b1n = 0;
      r1 = 'x; r5 = 'x; r16 = 'x;
      e1  = 2'(av[0]) + 2'(bv[0]) + 2'(cv);
      e5  = 6'(av[4:0]) + 6'(bv[4:0]) + 6'(cv);
      e16 = 17'(av) + 17'(bv) + 17'(cv);
      as = av; bs = bv; cs = cv; start_s = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         step();
         start_s = 1'b0;
         as = 16'(c * 16'h3579); bs = ~as; cs = ~cs;
         if (bsy1) b1n++;
         if (dn1)  begin d1  = c; r1  = {co1, sm1};   end
         if (dn5)  begin d5  = c; r5  = {co5, sm5};   end
         if (dn16) begin d16 = c; r16 = {co16, sm16}; end
      end
      check({tag, ".w1_busy"}, b1n, 1);
      check({tag, ".w1_done_at"}, d1, 2);
      check({tag, ".w5_done_at"}, d5, 6);
      check({tag, ".w16_done_at"}, d16, 17);
      check({tag, ".w1_res"}, 32'(r1), 32'(e1));
      check({tag, ".w5_res"}, 32'(r5), 32'(e5));
      check({tag, ".w16_res"}, 32'(r16), 32'(e16));
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int done_n, hold_ok;
      int dcyc[$];
      logic [7:0] s2;

      rst = 1'b1;
      repeat (2) step();
      rst = 1'b0;
      check("rst.ready", 32'(ready8), 32'd1);
      check("rst.busy",  32'(busy8),  32'd0);
      check("rst.done",  32'(done8),  32'd0);
      check("rst.sum",   {23'd0, cout8, sum8}, 32'd0);
      check("rst.small", {13'd0, co16, sm16, dn1, bsy5, rdy1}, 32'd1);

      op8("basic",   8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b0);
      op8("ripple1", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
      op8("ripple2", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
      op8("ignore",  8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b1);

      // Reset in cycle 3 of an operation.
      a8 = 8'h0F; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
      step(); start8 = 1'b0;
      step(); step();
      rst = 1'b1;
      step(); rst = 1'b0;
      check("rstmid.ready", 32'(ready8), 32'd1);
      check("rstmid.busy",  32'(busy8),  32'd0);
      check("rstmid.sum",   {23'd0, cout8, sum8}, 32'd0);
      done_n = 0;
      for (int c = 0; c < 12; c++) begin
         if (done8) done_n++;
         step();
      end
      check("rstmid.no_done", done_n, 0);
      op8("fresh", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);

      // Start held high: accepts in cycles 0 and 10.
      a8 = 8'h5A; b8 = 8'h3C; cin8 = 1'b0; start8 = 1'b1;
      hold_ok = 0; s2 = 'x;
      for (int c = 1; c <= 20; c++) begin
         step();
         if (done8) dcyc.push_back(c);
         if (c >= 9 && c <= 18 && sum8 == 8'h96) hold_ok++;
         if (c == 19) s2 = sum8;
         if (c == 10) begin a8 = 8'h01; b8 = 8'h02; end
         if (c == 19) start8 = 1'b0;
      end
      check("b2b.done_n", dcyc.size(), 2);
      if (dcyc.size() == 2) begin
         check("b2b.done1", dcyc[0], 9);
         check("b2b.done2", dcyc[1], 19);
      end
      check("b2b.hold", hold_ok, 10);
      check("b2b.sum2", 32'(s2), 32'h03);
      check("b2b.ready", 32'(ready8), 32'd1);

      // Narrow/wide builds.
      op_small("small_111", 16'h0001, 16'h0001, 1'b1);
      op_small("small_dir", 16'hFFFF, 16'h0000, 1'b1);
      op_small("small_mix", 16'h1234, 16'hEDCB, 1'b0);
      for (int i = 0; i < 6; i++)
         op_small($sformatf("small_rnd%0d", i), 16'($urandom_range(0, 65535)),
                  16'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
